// File: rtl/assert_event_monitor.sv
// Pass/fail collector for SVA checker channels: saturating counters, FWFT failure log, consecutive-fail alarms.
// Build option: define ASSERT_MON_ALARM_EN to compile in the per-channel run counters and alarm outputs.
module assert_event_monitor #(
  parameter int N      = 2,
  parameter int CNT_W  = 16,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         pass,
  input  logic [N-1:0]         fail,
  output logic [N*CNT_W-1:0]   pass_cnt,
  output logic [N*CNT_W-1:0]   fail_cnt,
  output logic                 log_valid,
  output logic [N+TS_W-1:0]    log_data,
  input  logic                 log_pop,
  output logic                 log_ovf,
  output logic [7:0]           drop_cnt,
  output logic [N-1:0]         proto_err,
  output logic [N-1:0]         alarm
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [TS_W-1:0]             ts;
  logic [N-1:0][CNT_W-1:0]     pass_q;
  logic [N-1:0][CNT_W-1:0]     fail_q;
  logic [N+TS_W-1:0]           mem [DEPTH];
  logic [AW-1:0]               rd_ptr;
  logic [AW-1:0]               wr_ptr;
  logic [AW:0]                 count;
  logic                        push;
  logic                        full;
  logic                        pop_ok;
  logic                        push_ok;
  logic                        drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= '0;
      fail_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (pass[i] && (pass_q[i] != '1)) pass_q[i] <= pass_q[i] + CNT_W'(1);
        if (fail[i] && (fail_q[i] != '1)) fail_q[i] <= fail_q[i] + CNT_W'(1);
      end
    end
  end

  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err <= '0;
    else     proto_err <= proto_err | (pass & fail);
  end

  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  always_comb begin
    push    = |fail;
    full    = (count == DEPTH_C);
    pop_ok  = log_pop && (count != '0);
    push_ok = push && (!full || pop_ok);
    drop    = push && full && !pop_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {fail, ts};
  end

  always_comb begin
    log_valid = (count != '0);
    log_data  = log_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_ovf  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      log_ovf <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef ASSERT_MON_ALARM_EN
  localparam int RW = (THRESH > 0) ? $clog2(THRESH + 1) : 1;
  localparam logic [RW-1:0] THRESH_R = RW'(THRESH);

  logic [N-1:0][RW-1:0] run;

  // Coincident pass and fail counts as a fail for the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (fail[i]) begin
          if (run[i] != THRESH_R) run[i] <= run[i] + RW'(1);
        end else if (pass[i]) begin
          run[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    alarm = '0;
    for (int unsigned i = 0; i < N; i++) alarm[i] = (run[i] == THRESH_R);
  end
`else
  always_comb alarm = '0;
`endif

endmodule
